// File: rtl/pairing_sched_pkg.sv
// rtl/pairing_sched_pkg.sv - shared state type, widths and default timing constants
//
// Purpose : common definitions for pairing_sched and sched_walk.
//           Global width defines (FUNCIDW, RFSZLOG2, WORDSZ, CORELOG2,
//           CORE_NUM) get defaults here only when the surrounding build has
//           not already defined them.
// Ports   : none (package).

`ifndef FUNCIDW
`define FUNCIDW 8
`endif
`ifndef RFSZLOG2
`define RFSZLOG2 8
`endif
`ifndef WORDSZ
`define WORDSZ 32
`endif
`ifndef CORELOG2
`define CORELOG2 1
`endif
`ifndef CORE_NUM
`define CORE_NUM 2
`endif

package pairing_sched_pkg;

   localparam int FUNCIDW  = `FUNCIDW;
   localparam int RFSZLOG2 = `RFSZLOG2;
   localparam int WORDSZ   = `WORDSZ;
   localparam int CORELOG2 = `CORELOG2;
   localparam int CORE_NUM = `CORE_NUM;

   localparam int RD_LAT_DEF      = 1;
   localparam int START_GUARD_DEF = 3;
   localparam int TIMEOUT_DEF     = 65535;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_RDREQ,
      ST_RDWAIT,
      ST_OUT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sched_walk.sv
// rtl/sched_walk.sv - core-major core/index walker with wrapped register-file address
//
// Purpose : walks idx 0..cnt-1 for each core 0..CORE_NUM-1 (idx fastest) and
//           presents addr = (base + idx) mod 2^RFSZLOG2. Shared by the load
//           and store phases; the owner switches base/cnt between phases.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           clr            - return to core 0 / idx 0
//           adv            - step to the next (core, idx) position
//           base, cnt      - window of the current phase
//           core, addr     - current position
//           last           - current position is the final one of the window

module sched_walk
   import pairing_sched_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                adv,
   input  logic [RFSZLOG2-1:0] base,
   input  logic [RFSZLOG2-1:0] cnt,
   output logic [CORELOG2-1:0] core,
   output logic [RFSZLOG2-1:0] addr,
   output logic                last
);

   localparam logic [CORELOG2-1:0] LAST_CORE = CORELOG2'(CORE_NUM - 1);

   logic [RFSZLOG2-1:0] idx;
   logic                idx_end;

   assign idx_end = (idx == cnt - RFSZLOG2'(1));
   assign last    = idx_end && (core == LAST_CORE);
   // Natural truncation of the sum is the register-file wrap.
   assign addr    = base + idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx  <= '0;
         core <= '0;
      end else if (clr) begin
         idx  <= '0;
         core <= '0;
      end else if (adv) begin
         if (idx_end) begin
            idx  <= '0;
            core <= core + CORELOG2'(1);
         end else begin
            idx  <= idx + RFSZLOG2'(1);
         end
      end
   end

endmodule

// File: rtl/pairing_sched.sv
// rtl/pairing_sched.sv - job scheduler that loads operands, starts the pairing core and streams results
//
// Purpose : accepts a job, writes CORE_NUM*ld_cnt operand beats into the
//           per-core register files, pulses m_start, waits for m_busy to
//           drop, then reads back CORE_NUM*st_cnt results onto the output
//           stream. Build macro PAIRING_SCHED_TIMEOUT_EN adds a WAIT
//           watchdog that raises err and ends the job.
// Ports   : clk, rst_n                       - clock, asynchronous active-low reset
//           job_valid/job_ready, job_*       - job handshake and fields
//           in_valid/in_ready/in_data        - operand stream
//           out_valid/out_ready/out_data     - result stream
//           m_funcid, m_start, m_wen, m_chip_sel, m_waddr, m_wdata,
//           m_ren, m_raddr                   - requests to the pairing top
//           m_rdata, m_busy                  - responses from the pairing top
//           done                             - one-cycle end-of-job pulse
//           err                              - watchdog fired, held until next job

module pairing_sched
   import pairing_sched_pkg::*;
#(
   parameter int RD_LAT      = RD_LAT_DEF,
   parameter int START_GUARD = START_GUARD_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [`FUNCIDW-1:0]   job_funcid,
   input  logic [`RFSZLOG2-1:0]  job_ld_base,
   input  logic [`RFSZLOG2-1:0]  job_ld_cnt,
   input  logic [`RFSZLOG2-1:0]  job_st_base,
   input  logic [`RFSZLOG2-1:0]  job_st_cnt,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [`WORDSZ-1:0]    in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [`WORDSZ-1:0]    out_data,
   output logic [`FUNCIDW-1:0]   m_funcid,
   output logic                  m_start,
   output logic                  m_wen,
   output logic [`CORELOG2-1:0]  m_chip_sel,
   output logic [`RFSZLOG2-1:0]  m_waddr,
   output logic [`WORDSZ-1:0]    m_wdata,
   output logic                  m_ren,
   output logic [`RFSZLOG2-1:0]  m_raddr,
   input  logic [`WORDSZ-1:0]    m_rdata,
   input  logic                  m_busy,
   output logic                  done,
   output logic                  err
);

   state_t state, state_nx;

   logic [`FUNCIDW-1:0]  funcid_q;
   logic [`RFSZLOG2-1:0] ld_base_q, ld_cnt_q, st_base_q, st_cnt_q;
   logic [`WORDSZ-1:0]   out_data_q;
   logic [15:0]          guard_cnt;
   logic [15:0]          lat_cnt;
   logic                 guard_done;
   logic                 lat_done;
   logic                 timeout_hit;
   logic                 timeout_take;

   logic                 walk_clr, walk_adv, walk_last;
   logic [`CORELOG2-1:0] walk_core;
   logic [`RFSZLOG2-1:0] walk_addr, walk_base, walk_cnt;

   // The walker serves the load window while loading and the store window otherwise.
   assign walk_base = (state == ST_LOAD) ? ld_base_q : st_base_q;
   assign walk_cnt  = (state == ST_LOAD) ? ld_cnt_q  : st_cnt_q;

   sched_walk u_walk (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (walk_clr),
      .adv   (walk_adv),
      .base  (walk_base),
      .cnt   (walk_cnt),
      .core  (walk_core),
      .addr  (walk_addr),
      .last  (walk_last)
   );

   assign guard_done = (guard_cnt >= 16'(START_GUARD));
   assign lat_done   = (lat_cnt == 16'(RD_LAT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      job_ready    = 1'b0;
      in_ready     = 1'b0;
      m_start      = 1'b0;
      m_wen        = 1'b0;
      m_ren        = 1'b0;
      out_valid    = 1'b0;
      done         = 1'b0;
      walk_clr     = 1'b0;
      walk_adv     = 1'b0;
      timeout_take = 1'b0;
      m_waddr      = '0;
      m_raddr      = '0;
      m_wdata      = '0;
      case (state)
         ST_IDLE: begin
            job_ready = 1'b1;
            if (job_valid) begin
               walk_clr = 1'b1;
               state_nx = (job_ld_cnt == '0) ? ST_START : ST_LOAD;
            end
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            m_waddr  = walk_addr;
            if (in_valid) begin
               m_wen    = 1'b1;
               m_wdata  = in_data;
               walk_adv = 1'b1;
               if (walk_last) state_nx = ST_START;
            end
         end
         ST_START: begin
            m_start  = 1'b1;
            walk_clr = 1'b1;   // rewind for the store window
            state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            // A genuine completion wins over a watchdog expiry in the same cycle.
            if (guard_done && !m_busy) begin
               state_nx = (st_cnt_q == '0) ? ST_DONE : ST_RDREQ;
            end else if (timeout_hit) begin
               timeout_take = 1'b1;
               state_nx     = ST_DONE;
            end
         end
         ST_RDREQ: begin
            m_ren    = 1'b1;
            m_raddr  = walk_addr;
            state_nx = ST_RDWAIT;
         end
         ST_RDWAIT: begin
            m_raddr = walk_addr;
            if (lat_done) state_nx = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               walk_adv = 1'b1;
               state_nx = walk_last ? ST_DONE : ST_RDREQ;
            end
         end
         ST_DONE: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // The core index stays registered through RDWAIT, so the top's rdata mux
   // keeps selecting the core that was addressed.
   assign m_chip_sel = walk_core;
   assign m_funcid   = funcid_q;
   assign out_data   = out_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         funcid_q  <= '0;
         ld_base_q <= '0;
         ld_cnt_q  <= '0;
         st_base_q <= '0;
         st_cnt_q  <= '0;
      end else if (state == ST_IDLE && job_valid) begin
         funcid_q  <= job_funcid;
         ld_base_q <= job_ld_base;
         ld_cnt_q  <= job_ld_cnt;
         st_base_q <= job_st_base;
         st_cnt_q  <= job_st_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         guard_cnt <= '0;
      end else if (state != ST_WAIT) begin
         guard_cnt <= '0;
      end else if (!guard_done) begin
         guard_cnt <= guard_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_cnt    <= '0;
         out_data_q <= '0;
      end else if (state == ST_RDWAIT) begin
         lat_cnt <= lat_cnt + 16'd1;
         if (lat_done) out_data_q <= m_rdata;
      end else begin
         lat_cnt <= '0;
      end
   end

`ifdef PAIRING_SCHED_TIMEOUT_EN
   logic [31:0] to_cnt;
   logic        err_q;

   assign timeout_hit = (to_cnt == 32'(TIMEOUT - 1));
   assign err         = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (state != ST_WAIT) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (state == ST_IDLE && job_valid) begin
         err_q <= 1'b0;
      end else if (timeout_take) begin
         err_q <= 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign timeout_hit    = 1'b0;
   assign err            = 1'b0;
   assign unused_timeout = (TIMEOUT == 0) | timeout_take;
`endif

endmodule

// File: tb/tb_pairing_sched.sv
// tb/tb_pairing_sched.sv - randomized scoreboard bench for pairing_sched

`timescale 1ns/1ps

module tb_pairing_sched;
   import pairing_sched_pkg::*;

   localparam int TB_RD_LAT  = 1;
   localparam int TB_GUARD   = 3;
   localparam int TB_TIMEOUT = 100;
   localparam int NW         = 1 << RFSZLOG2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 job_valid = 1'b0;
   logic                 job_ready;
   logic [FUNCIDW-1:0]   job_funcid = '0;
   logic [RFSZLOG2-1:0]  job_ld_base = '0, job_ld_cnt = '0, job_st_base = '0, job_st_cnt = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [WORDSZ-1:0]    in_data = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [WORDSZ-1:0]    out_data;
   logic [FUNCIDW-1:0]   m_funcid;
   logic                 m_start, m_wen, m_ren;
   logic [CORELOG2-1:0]  m_chip_sel;
   logic [RFSZLOG2-1:0]  m_waddr, m_raddr;
   logic [WORDSZ-1:0]    m_wdata;
   logic [WORDSZ-1:0]    m_rdata = '0;
   logic                 m_busy = 1'b0;
   logic                 done, err;

   always #5 clk = ~clk;

   pairing_sched #(.RD_LAT(TB_RD_LAT), .START_GUARD(TB_GUARD), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready), .job_funcid(job_funcid),
      .job_ld_base(job_ld_base), .job_ld_cnt(job_ld_cnt),
      .job_st_base(job_st_base), .job_st_cnt(job_st_cnt),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .m_funcid(m_funcid), .m_start(m_start), .m_wen(m_wen), .m_chip_sel(m_chip_sel),
      .m_waddr(m_waddr), .m_wdata(m_wdata), .m_ren(m_ren), .m_raddr(m_raddr),
      .m_rdata(m_rdata), .m_busy(m_busy), .done(done), .err(err)
   );

   int tests = 0;
   int fails = 0;

   function automatic void chk(input string name, input longint unsigned act, input longint unsigned exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   typedef struct {
      int             core;
      int             addr;
      logic [WORDSZ-1:0] data;
   } xfer_t;

   xfer_t exp_wr[$];
   xfer_t exp_out[$];

   // tmem is the register file the DUT actually writes; ref_mem is what the
   // job sequence should have produced.
   logic [WORDSZ-1:0] tmem    [CORE_NUM][NW];
   logic [WORDSZ-1:0] ref_mem [CORE_NUM][NW];

   int  cyc = 0;
   int  exp_funcid = 0;
   bit  exp_err = 1'b0;
   int  b_rise = 0, b_fall = 0;
   bit  b_stuck = 1'b0;
   bit  started = 1'b0;
   int  start_cyc = -1000;
   bit  evt_pending = 1'b0;
   int  exp_evt = 0;
   int  done_cnt = 0;
   int  rq_cyc = -1000;
   logic [WORDSZ-1:0] rq_data = '0;
   bit  prev_ov = 1'b0, prev_or = 1'b0;
   logic [WORDSZ-1:0] prev_od = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic init_mems();
      for (int c = 0; c < CORE_NUM; c++)
         for (int a = 0; a < NW; a++) begin
            tmem[c][a]    = WORDSZ'(32'hC0DE0000 + c * 1024 + a);
            ref_mem[c][a] = WORDSZ'(32'hC0DE0000 + c * 1024 + a);
         end
   endtask

   // Pairing-top model: busy profile relative to m_start, read data RD_LAT cycles after m_ren.
   always @(posedge clk) begin
      #1;
      if (b_stuck && started) m_busy = 1'b1;
      else if (started) m_busy = ((cyc - start_cyc) >= b_rise) && ((cyc - start_cyc) < b_fall);
      else m_busy = 1'b0;
      m_rdata = (cyc == rq_cyc + TB_RD_LAT) ? rq_data : WORDSZ'($urandom);
   end

   always @(negedge clk) begin : monitor
      xfer_t x;
      int    k;
      if (rst_n) begin
         chk("wen_ren_exclusive", {m_wen, m_ren}, 2'b00 | {m_wen & ~m_ren, m_ren & ~m_wen});
         if (m_wen) begin
            if (exp_wr.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_write: got core %0d addr %0d data %0h, required no write", m_chip_sel, m_waddr, m_wdata);
            end else begin
               x = exp_wr.pop_front();
               chk("wr_core", m_chip_sel, x.core);
               chk("wr_addr", m_waddr, x.addr);
               chk("wr_data", m_wdata, x.data);
            end
            tmem[m_chip_sel][m_waddr] = m_wdata;
         end
         if (m_start) begin
            chk("start_funcid", m_funcid, exp_funcid);
            started   = 1'b1;
            start_cyc = cyc;
            if (b_stuck) begin
               exp_evt = cyc + TB_TIMEOUT + 1;
            end else begin
               k = TB_GUARD + 1;
               while (k >= b_rise && k < b_fall) k++;
               exp_evt = cyc + k + 1;
            end
            evt_pending = 1'b1;
         end
         if (evt_pending && (m_ren || done)) begin
            chk("wait_exit_cycle", cyc - start_cyc, exp_evt - start_cyc);
            evt_pending = 1'b0;
         end
         if (m_ren) begin
            if (exp_out.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_read: got core %0d addr %0d, required no read", m_chip_sel, m_raddr);
            end else begin
               chk("rd_core", m_chip_sel, exp_out[0].core);
               chk("rd_addr", m_raddr, exp_out[0].addr);
            end
            rq_cyc  = cyc;
            rq_data = tmem[m_chip_sel][m_raddr];
         end
         if (prev_ov && !prev_or) begin
            chk("out_valid_hold", out_valid, 1);
            chk("out_data_hold", out_data, prev_od);
         end
         if (out_valid) begin
            if (exp_out.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_out: got %0h, required no output", out_data);
            end else begin
               chk("out_chip_sel", m_chip_sel, exp_out[0].core);
               if (out_ready) begin
                  x = exp_out.pop_front();
                  chk("out_data", out_data, x.data);
               end
            end
         end
         prev_ov = out_valid;
         prev_or = out_ready;
         prev_od = out_data;
         if (done) begin
            done_cnt++;
            chk("done_err", err, exp_err);
            chk("done_funcid_hold", m_funcid, exp_funcid);
            started = 1'b0;
         end
      end else begin
         prev_ov = 1'b0;
      end
   end

   task automatic accept_job(input int fid, input int ldb, input int ldc, input int stb, input int stc);
      bit acc = 1'b0;
      int n = 0;
      job_funcid  = FUNCIDW'(fid);
      job_ld_base = RFSZLOG2'(ldb);
      job_ld_cnt  = RFSZLOG2'(ldc);
      job_st_base = RFSZLOG2'(stb);
      job_st_cnt  = RFSZLOG2'(stc);
      job_valid   = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = job_ready;
         @(posedge clk); #1;
         n++;
      end
      job_valid = 1'b0;
      chk("job_accept", acc, 1);
   endtask

   task automatic run_job(input int fid, input int ldb, input int ldc, input int stb, input int stc,
                          input int rise, input int fall, input bit stuck, input int ormode);
      logic [WORDSZ-1:0] din[$];
      logic [WORDSZ-1:0] w;
      int total, i, n, hold, d0, a;
      total = CORE_NUM * ldc;
      for (int c = 0; c < CORE_NUM; c++)
         for (int j = 0; j < ldc; j++) begin
            w = WORDSZ'($urandom);
            a = (ldb + j) % NW;
            din.push_back(w);
            exp_wr.push_back('{core: c, addr: a, data: w});
            ref_mem[c][a] = w;
         end
      if (!stuck)
         for (int c = 0; c < CORE_NUM; c++)
            for (int j = 0; j < stc; j++) begin
               a = (stb + j) % NW;
               exp_out.push_back('{core: c, addr: a, data: ref_mem[c][a]});
            end
      exp_funcid = fid;
      exp_err    = stuck;
      b_rise     = rise;
      b_fall     = fall;
      b_stuck    = stuck;
      d0         = done_cnt;
      accept_job(fid, ldb, ldc, stb, stc);
      i = 0;
      n = 0;
      while (i < total && n < 5000) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         in_data    = in_valid ? din[i] : WORDSZ'($urandom);
         job_valid  = $urandom_range(0, 1);     // must be ignored outside IDLE
         job_funcid = FUNCIDW'($urandom);
         @(negedge clk);
         if (in_valid && in_ready) i++;
         @(posedge clk); #1;
         n++;
      end
      job_valid = 1'b0;
      chk("load_beats", i, total);
      hold      = (ormode == 1) ? 10 : 0;
      out_ready = (ormode == 1) ? 1'b0 : 1'b1;
      n = 0;
      while (done_cnt == d0 && n < 20000) begin
         in_valid = $urandom_range(0, 1);        // must not be consumed outside LOAD
         in_data  = WORDSZ'($urandom);
         @(negedge clk);
         if (out_valid && hold > 0) hold--;
         @(posedge clk); #1;
         n++;
         case (ormode)
            1:       out_ready = (hold == 0);
            2:       out_ready = 1'b1;
            default: out_ready = $urandom_range(0, 1);
         endcase
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("job_done_count", done_cnt - d0, 1);
      chk("wr_queue_empty", exp_wr.size(), 0);
      chk("out_queue_empty", exp_out.size(), 0);
      @(negedge clk);
      chk("idle_job_ready", job_ready, 1);
      b_stuck = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic reset_mid_load();
      logic [WORDSZ-1:0] w;
      exp_funcid = 8'h66;
      exp_err    = 1'b0;
      accept_job(8'h66, 10, 5, 0, 1);
      for (int j = 0; j < 3; j++) begin
         w = WORDSZ'($urandom);
         exp_wr.push_back('{core: 0, addr: 10 + j, data: w});
         in_valid = 1'b1;
         in_data  = w;
         @(negedge clk);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = WORDSZ'($urandom);
      #1;
      chk("pre_reset_wen", m_wen, 1);
      chk("pre_reset_waddr", m_waddr, 13);
      chk("pre_reset_wq_empty", exp_wr.size(), 0);
      rst_n = 1'b0;
      #1;
      chk("rst_m_wen", m_wen, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_m_waddr", m_waddr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_m_chip_sel", m_chip_sel, 0);
      chk("rst_m_start", m_start, 0);
      chk("rst_m_ren", m_ren, 0);
      exp_wr.delete();
      exp_out.delete();
      evt_pending = 1'b0;
      started     = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b1;
      init_mems();
      @(negedge clk);
      chk("post_reset_job_ready", job_ready, 1);
      chk("post_reset_in_ready", in_ready, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL global_time_limit: simulation did not finish, required completion");
      $fatal(1, "time limit");
   end

   initial begin
      init_mems();
      in_valid = 1'b1;
      in_data  = WORDSZ'(32'hDEADBEEF);
      #23;
      chk("reset_m_start", m_start, 0);
      chk("reset_m_wen", m_wen, 0);
      chk("reset_m_ren", m_ren, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_m_chip_sel", m_chip_sel, 0);
      chk("reset_m_waddr", m_waddr, 0);
      chk("reset_m_raddr", m_raddr, 0);
      chk("reset_m_wdata", m_wdata, 0);
      chk("reset_out_data", out_data, 0);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("release_job_ready", job_ready, 1);
      @(posedge clk); #1;

      run_job(8'h11, 4, 3, 4, 3, 2, 50, 1'b0, 0);      // core-major load, busy falls at 50
      run_job(8'h22, 254, 3, 254, 3, 1, 1, 1'b0, 0);   // address wrap 254,255,0
      run_job(8'h33, 0, 1, 4, 2, 0, 20, 1'b0, 1);      // out_ready held low 10 cycles
      run_job(8'h44, 9, 0, 3, 0, 0, 6, 1'b0, 0);       // both phases skipped
      run_job(8'h55, 7, NW - 1, 200, NW - 1, 5, 12, 1'b0, 2);  // full-size windows with wrap
      reset_mid_load();
      run_job(8'h77, 100, 2, 100, 2, 0, 0, 1'b0, 0);   // recovery after reset
      for (int r = 0; r < 8; r++) begin
         int rise;
         rise = $urandom_range(0, 8);
         run_job($urandom_range(0, 255), $urandom_range(0, NW - 1), $urandom_range(0, 6),
                 $urandom_range(0, NW - 1), $urandom_range(0, 6),
                 rise, rise + $urandom_range(0, 30), 1'b0, $urandom_range(0, 2));
      end
`ifdef PAIRING_SCHED_TIMEOUT_EN
      run_job(8'h88, 20, 1, 20, 2, 0, 0, 1'b1, 2);     // busy stuck: watchdog ends job
      run_job(8'h99, 20, 1, 20, 1, 0, 3, 1'b0, 2);     // err clears on next accept
`endif
      chk("final_err", err, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
